// File: rtl/niosiie_switch_pio_if.sv
// Avalon-MM slave bus bundle for the switch input PIO.
// Zero-wait-state register access: address/select/strobe in, readdata out.
interface niosiie_switch_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/niosiie_switch_pio.sv
// Switch/button input PIO: sync, edge capture, maskable level irq.
// Optional per-bit debounce filter enabled by NIOSIIE_SWITCH_DEBOUNCE_EN.
module niosiie_switch_pio #(
  parameter int WIDTH           = 10,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  niosiie_switch_pio_if.slave    bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ecap;
  logic [1:0]       r_arm;

  logic [WIDTH-1:0] w_cond;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd;
  logic             w_wr;
  logic             w_armed;

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_armed = (r_arm == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_arm   <= 2'd0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= w_cond;
      if (!w_armed)
        r_arm <= r_arm + 2'd1;
    end
  end

`ifdef NIOSIIE_SWITCH_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_cond;

  // A bit only follows sync2 after disagreeing for the full window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cond <= '0;
      for (int i = 0; i < WIDTH; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] != r_cond[i]) begin
          if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cond[i] <= r_sync2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i]  <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_cond = r_cond;
`else
  assign w_cond = r_sync2;
`endif

  always_comb begin
    w_edge = w_cond & ~r_prev;
    if (EDGE_TYPE == 1)
      w_edge = ~w_cond & r_prev;
    else if (EDGE_TYPE == 2)
      w_edge = w_cond ^ r_prev;
  end

  assign w_clr = (w_wr && bus.address == 2'd3) ?
                 bus.writedata[WIDTH-1:0] : '0;

  // A new edge wins over a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_ecap <= '0;
    end else begin
      if (w_wr && bus.address == 2'd2)
        r_mask <= bus.writedata[WIDTH-1:0];
      r_ecap <= (r_ecap & ~w_clr) |
                (w_armed ? w_edge : '0);
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (bus.address)
      2'd0:    w_rd[WIDTH-1:0] = w_cond;
      2'd2:    w_rd[WIDTH-1:0] = r_mask;
      2'd3:    w_rd[WIDTH-1:0] = r_ecap;
      default: w_rd = '0;
    endcase
  end

  assign bus.readdata = w_rd;
  assign irq          = |(r_ecap & r_mask);

endmodule
